// File: rtl/ula_issue_control.sv
// ula_issue_control
// Issue/writeback controller driving the Ula ALU port. Accepts one MIPS
// R-type, ADDI or ANDI instruction per handshake, reads its operands from an
// internal 32x32 register file and presents them to the ALU. It then captures
// the combinational ALU result and writes it back to rd (R-type) or rt (I-type).
//
// Ports:
//   clk, reset        - single clock; asynchronous active-high reset
//   instr/instrValid  - instruction word and its valid strobe
//   instrReady        - high only while idle (one instruction in flight)
//   input1/input2     - registered ALU operands (rs value, rt value or imm)
//   shamt/aluOp/funct - registered ALU control (aluOp 0=add, 1=and, 2=funct)
//   aluResult         - combinational ALU result for the driven operands
//   done              - one-cycle retire pulse
//   overflow/illegal  - retire qualifiers, only ever high together with done
//   dbgAddr/dbgData   - combinational debug read port, register 0 reads 0
module ula_issue_control #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  instr,
    input  logic                         instrValid,
    output logic                         instrReady,
    output logic signed [DATA_WIDTH-1:0] input1,
    output logic signed [DATA_WIDTH-1:0] input2,
    output logic [4:0]                   shamt,
    output logic [1:0]                   aluOp,
    output logic [5:0]                   funct,
    input  logic [DATA_WIDTH-1:0]        aluResult,
    output logic                         done,
    output logic                         overflow,
    output logic                         illegal,
    input  logic [REG_ADDR_W-1:0]        dbgAddr,
    output logic [DATA_WIDTH-1:0]        dbgData
);

    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   input1_q, input1_d;
    logic [DATA_WIDTH-1:0]   input2_q, input2_d;
    logic [4:0]              shamt_q, shamt_d;
    logic [1:0]              aluop_q, aluop_d;
    logic [5:0]              funct_q, funct_d;
    logic [REG_ADDR_W-1:0]   dest_q, dest_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    overflow_q, overflow_d;
    logic                    illegal_q, illegal_d;

    // Register file has no reset so that contents survive a reset.
    logic [DATA_WIDTH-1:0]   regs [2**REG_ADDR_W];

    logic [5:0]              dec_opcode;
    logic [4:0]              dec_rs, dec_rt, dec_rd;
    logic [15:0]             dec_imm;
    logic                    dec_rtype, dec_addi, dec_andi, dec_funct_ok, dec_illegal;
    logic [DATA_WIDTH-1:0]   rs_val, rt_val;
    logic                    op_add, op_sub, add_ovf, sub_ovf;
    logic                    accept, reg_we;

    assign dec_opcode = instr_q[31:26];
    assign dec_rs     = instr_q[25:21];
    assign dec_rt     = instr_q[20:16];
    assign dec_rd     = instr_q[15:11];
    assign dec_imm    = instr_q[15:0];

    assign dec_rtype = (dec_opcode == 6'd0);
    assign dec_addi  = (dec_opcode == 6'd8);
    assign dec_andi  = (dec_opcode == 6'd12);

    // Supported R-type functions: SLL, SRL, SRA, ADD, SUB, AND, OR, SLT.
    always_comb begin
        case (instr_q[5:0])
            6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42: dec_funct_ok = 1'b1;
            default:                                             dec_funct_ok = 1'b0;
        endcase
    end

    assign dec_illegal = !((dec_rtype && dec_funct_ok) || dec_addi || dec_andi);

    // Register 0 is never written, so its storage is undefined; gate it on read.
    assign rs_val  = (dec_rs == '0)  ? '0 : regs[dec_rs];
    assign rt_val  = (dec_rt == '0)  ? '0 : regs[dec_rt];
    assign dbgData = (dbgAddr == '0) ? '0 : regs[dbgAddr];

    // Overflow uses the held operands, which are exactly what the ALU sees.
    assign op_add  = (aluop_q == 2'd0) || ((aluop_q == 2'd2) && (funct_q == 6'd32));
    assign op_sub  = (aluop_q == 2'd2) && (funct_q == 6'd34);
    assign add_ovf = (input1_q[MSB] == input2_q[MSB]) && (aluResult[MSB] != input1_q[MSB]);
    assign sub_ovf = (input1_q[MSB] != input2_q[MSB]) && (aluResult[MSB] != input1_q[MSB]);

    assign accept = (state_q == ST_IDLE) && instrValid;
    assign reg_we = (state_q == ST_WRITEBACK) && !overflow_q && !illegal_q && (dest_q != '0);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; illegal instructions skip the execute cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (instrValid) state_d = ST_DECODE;
            ST_DECODE:    state_d = dec_illegal ? ST_WRITEBACK : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the flags are masked so they can only appear with done.
    always_comb begin
        instrReady = (state_q == ST_IDLE);
        done       = (state_q == ST_WRITEBACK);
        overflow   = (state_q == ST_WRITEBACK) && overflow_q;
        illegal    = (state_q == ST_WRITEBACK) && illegal_q;
    end

    // Datapath next values. ALU outputs hold unless a legal decode loads them.
    always_comb begin
        instr_d    = instr_q;
        input1_d   = input1_q;
        input2_d   = input2_q;
        shamt_d    = shamt_q;
        aluop_d    = aluop_q;
        funct_d    = funct_q;
        dest_d     = dest_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d    = instr;
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            ST_DECODE: begin
                illegal_d = dec_illegal;
                if (!dec_illegal) begin
                    input1_d = rs_val;
                    if (dec_rtype) begin
                        input2_d = rt_val;
                        shamt_d  = instr_q[10:6];
                        aluop_d  = 2'd2;
                        funct_d  = instr_q[5:0];
                        dest_d   = dec_rd;
                    end else begin
                        // ADDI sign-extends its immediate, ANDI zero-extends it.
                        input2_d = dec_addi ? {{(DATA_WIDTH-16){dec_imm[15]}}, dec_imm}
                                            : {{(DATA_WIDTH-16){1'b0}}, dec_imm};
                        shamt_d  = 5'd0;
                        aluop_d  = dec_addi ? 2'd0 : 2'd1;
                        funct_d  = 6'd0;
                        dest_d   = dec_rt;
                    end
                end
            end
            ST_EXECUTE: begin
                result_d   = aluResult;
                overflow_d = (op_add && add_ovf) || (op_sub && sub_ovf);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= '0;
            input1_q   <= '0;
            input2_q   <= '0;
            shamt_q    <= '0;
            aluop_q    <= '0;
            funct_q    <= '0;
            dest_q     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            input1_q   <= input1_d;
            input2_q   <= input2_d;
            shamt_q    <= shamt_d;
            aluop_q    <= aluop_d;
            funct_q    <= funct_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    // Register file write port; reset forces IDLE, which blocks any write.
    always_ff @(posedge clk) begin
        if (reg_we) begin
            regs[dest_q] <= result_q;
        end
    end

    assign input1 = input1_q;
    assign input2 = input2_q;
    assign shamt  = shamt_q;
    assign aluOp  = aluop_q;
    assign funct  = funct_q;

endmodule

// File: doc/ula_issue_control.md
# ula_issue_control

Multi-cycle issue/writeback controller that drives the Ula ALU port: accepts one MIPS R-type or ADDI/ANDI instruction per handshake and reads operands from an internal 32x32 register file. It then presents input1/input2/shamt/aluOp/funct to the ALU, captures the ALU result and writes it back to rd/rt. It is the initiator side of the ALU interface and sits between instruction delivery and the Ula instance in the datapath.

## Interface

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- REG_ADDR_W, 5, register index width (32 registers).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- instr  in  32  instruction word, sampled on accept.
- instrValid  in  1  instr is valid.
- instrReady  out  1  controller can accept; high only in IDLE.
- input1  out  32  ALU operand 1 (rs value), signed.
- input2  out  32  ALU operand 2 (rt value or extended immediate), signed.
- shamt  out  5  ALU shift amount (instr[10:6]; 0 for I-type).
- aluOp  out  2  0 = add (ADDI), 1 = and (ANDI), 2 = R-type via funct.
- funct  out  6  instr[5:0] for R-type, 0 for I-type.
- aluResult  in  32  combinational ALU result for the driven operands.
- done  out  1  one-cycle pulse when an instruction retires (written, overflowed or illegal).
- overflow  out  1  valid with done: signed overflow on ADD/SUB/ADDI, no writeback.
- illegal  out  1  valid with done: unsupported opcode/funct, no writeback.
- dbgAddr  in  5  debug register read index.
- dbgData  out  32  combinational read of register dbgAddr; reg 0 reads 0.

## Operation

- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: instrReady=1. instrValid&&instrReady latches instr and moves to DECODE. No accept in any other state.
- DECODE: classify opcode instr[31:26]:
  - 0 = R-type; funct in {0 SLL, 2 SRL, 3 SRA, 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT} is legal.
  - 8 = ADDI: immediate sign-extended.
  - 12 = ANDI: immediate zero-extended.
  - Anything else is illegal.
  - Read rs and rt, then register input1/input2/shamt/aluOp/funct. Dest = rd (R-type) or rt (I-type). Go to EXECUTE.
  - Illegal instructions go directly to WRITEBACK with illegal latched and outputs unchanged.
- EXECUTE: ALU outputs are held stable. aluResult is sampled at the end of the cycle.
  - Overflow detection:
    - ADD/ADDI: operand signs equal and result sign differs.
    - SUB: operand signs differ and result sign differs from input1.
  - Go to WRITEBACK.
- WRITEBACK: write the sampled result to dest unless dest==0, overflow or illegal. Pulse done with overflow/illegal qualifiers. Return to IDLE.
- Register 0 is hardwired to 0; writes to it are dropped silently (done still pulses, flags 0).
- ALU outputs hold their last values outside DECODE/EXECUTE updates (no return to zero).
- Register file is not cleared by reset. Only FSM, ALU outputs and flags are reset.

## Timing

- Reset values: state IDLE, instrReady=1, done=0, overflow=0, illegal=0, input1=input2=0, shamt=0, aluOp=0, funct=0.
- Accept at edge T → DECODE in T+1 → ALU outputs valid from edge T+2 (EXECUTE) → result sampled at edge T+3 → done high during cycle T+3 (WRITEBACK), register written at edge T+4.
- Latency: 4 cycles accept-to-register-visible. Throughput: 1 instruction per 4 cycles. instrReady is high again in cycle T+4.
- A back-to-back dependent instruction accepted at T+4 reads the updated value; no forwarding is needed.
- dbgData reflects a writeback in the cycle after the WRITEBACK edge.
- aluResult must settle within one cycle of the operand change (combinational ALU).
- Reset asserted mid-instruction: immediate return to IDLE, no writeback of the in-flight instruction, done/flags cleared. Register contents written before reset are preserved.
- overflow and illegal are asserted only while done=1; they are never set together.

## Test plan

- Reset, then ADDI $1,$0,5 (0x20010005) → input1=0, input2=5, aluOp=0 in EXECUTE; done after 4 cycles; dbgData[$1]=5.
- ADDI $2,$0,-3, then ADD $3,$1,$2 (funct 32) → aluOp=2, funct=32; $3=2. SUB $4,$2,$1 → $4=-8. SLT $5,$2,$1 → $5=1.
- ANDI $6,$2,0xFFFF → input2=0x0000FFFF (zero-extended); $6=0x0000FFFD. SLL $7,$1,4 → shamt=4, $7=80. SRA $8,$2,1 → $8=-2.
- Build $9=0x7FFFFFFF, then ADD $10,$9,$1 → done with overflow=1; $10 unchanged.
- Opcode 0x23 (LW) and R-type funct 8 → done with illegal=1; no register changes. Write to $0 → $0 still reads 0.
- Assert reset during EXECUTE of ADDI $11,$0,7 → instrReady=1 next cycle, done never pulses, $11 keeps its old value. instrValid held high during non-IDLE states is not accepted until IDLE.
